// File: rtl/tess_topo_tri_pkg.sv
// Shared types for the triangle-domain tessellation topology stage.
package tess_pkg;
  localparam int TESS_LVL_W = 8;
  localparam int TESS_IDX_W = 16;

  typedef struct packed {
    logic [TESS_IDX_W-1:0] v0;
    logic [TESS_IDX_W-1:0] v1;
    logic [TESS_IDX_W-1:0] v2;
    logic                  last;
  } tess_tri_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} tess_state_e;

  // Domain points in a triangle patch of level L: (L+1)(L+2)/2.
  function automatic logic [31:0] tess_num_points(input logic [TESS_LVL_W-1:0] lvl);
    logic [31:0] l;
    l = {24'd0, lvl};
    return ((l + 32'd1) * (l + 32'd2)) >> 1;
  endfunction
endpackage

// File: rtl/tess_topo_tri_fifo.sv
// Triangle FIFO: up to two pushes and one pop per cycle; flush empties it.
module tess_tri_fifo
  import tess_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = $bits(tess_tri_t)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push0,
  input  logic          push1,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic [AW:0]   free
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, wr1;
  logic [AW:0]   cnt_q, cnt_d;
  logic [AW:0]   n_push;
  logic          pop_ok;

  assign wr1    = wr_q + AW'(1);
  assign n_push = (AW+1)'(push0) + (AW+1)'(push1);
  assign pop_ok = pop && (cnt_q != '0);
  assign cnt_d  = cnt_q + n_push - (AW+1)'(pop_ok);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_q + AW'(pop_ok);
      wr_q  <= wr_q + n_push[AW-1:0];
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: nothing is read out while the count is zero.
  always_ff @(posedge clk) begin
    if (push0) mem_q[wr_q] <= din0;
    if (push1) mem_q[wr1]  <= din1;
  end

  assign dout  = mem_q[rd_q];
  assign empty = (cnt_q == '0);
  assign free  = (AW+1)'(DEPTH) - cnt_q;
endmodule

// File: rtl/tess_topo_tri.sv
// Turns the (i,j) barycentric point walk of a triangle patch into indexed
// triangles (DOWN then UP per point), checking the walk order on the way.
module tess_topo_tri
  import tess_pkg::*;
#(
  parameter int IDX_W      = TESS_IDX_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       tess_level,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_i,
  input  logic [7:0]       in_j,
  input  logic             in_last,
  output logic             tri_valid,
  input  logic             tri_ready,
  output logic [IDX_W-1:0] tri_v0,
  output logic [IDX_W-1:0] tri_v1,
  output logic [IDX_W-1:0] tri_v2,
  output logic             tri_last,
  output logic             busy,
  output logic             seq_err
);
  localparam int FAW = $clog2(FIFO_DEPTH);

  tess_state_e      state_q;
  logic [7:0]       lvl_q, exp_i_q, exp_j_q;
  logic [IDX_W-1:0] vidx_q, row_base_q, prev_base_q;
  logic             seq_err_q;

  logic             acc, row_start, row_end, last_pt, mismatch;
  logic             has_down, has_up, fifo_empty;
  logic [FAW:0]     fifo_free;
  logic [IDX_W-1:0] p, pj;
  tess_tri_t        down_tri, up_tri, head;

  assign in_ready = (state_q == RUN) && !start && (fifo_free >= (FAW+1)'(2));
  assign acc      = in_valid && in_ready;

  // First point of a row rolls the bases; the triangle must see the new ones.
  assign row_start = (exp_j_q == 8'd0) && (exp_i_q != 8'd0);
  assign row_end   = (exp_j_q == lvl_q - exp_i_q);
  assign last_pt   = (exp_i_q == lvl_q) && (exp_j_q == 8'd0);
  assign mismatch  = (in_i != exp_i_q) || (in_j != exp_j_q) || (in_last && !last_pt);
  assign p         = row_start ? row_base_q : prev_base_q;
  assign pj        = p + IDX_W'(exp_j_q);
  assign has_up    = (exp_i_q != 8'd0);
  assign has_down  = has_up && (exp_j_q != 8'd0);

  always_comb begin
    down_tri      = '0;
    down_tri.v0   = vidx_q - 1'b1;
    down_tri.v1   = pj;
    down_tri.v2   = vidx_q;
    up_tri        = '0;
    up_tri.v0     = pj;
    up_tri.v1     = pj + 1'b1;
    up_tri.v2     = vidx_q;
    up_tri.last   = in_last;
  end

  tess_tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .push0 (acc && has_up),
    .push1 (acc && has_down),
    .din0  (has_down ? down_tri : up_tri),
    .din1  (up_tri),
    .pop   (tri_valid && tri_ready),
    .dout  (head),
    .empty (fifo_empty),
    .free  (fifo_free)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lvl_q       <= 8'd1;
      exp_i_q     <= '0;
      exp_j_q     <= '0;
      vidx_q      <= '0;
      row_base_q  <= '0;
      prev_base_q <= '0;
      seq_err_q   <= 1'b0;
    end else if (start) begin
      state_q     <= RUN;
      lvl_q       <= (tess_level == 8'd0) ? 8'd1 : tess_level;
      exp_i_q     <= '0;
      exp_j_q     <= '0;
      vidx_q      <= '0;
      row_base_q  <= '0;
      prev_base_q <= '0;
      seq_err_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (acc) begin
          vidx_q <= vidx_q + 1'b1;
          if (row_start) begin
            prev_base_q <= row_base_q;
            row_base_q  <= vidx_q;
          end
          if (row_end) begin
            exp_i_q <= exp_i_q + 8'd1;
            exp_j_q <= '0;
          end else begin
            exp_j_q <= exp_j_q + 8'd1;
          end
          if (mismatch) seq_err_q <= 1'b1;
          if (in_last)  state_q   <= DRAIN;
        end
        DRAIN: if (fifo_empty) state_q <= IDLE;
        default: state_q <= state_q;
      endcase
    end
  end

  assign tri_valid = !fifo_empty;
  assign tri_v0    = tri_valid ? head.v0 : '0;
  assign tri_v1    = tri_valid ? head.v1 : '0;
  assign tri_v2    = tri_valid ? head.v2 : '0;
  assign tri_last  = tri_valid && head.last;
  assign busy      = (state_q != IDLE) || !fifo_empty;
  assign seq_err   = seq_err_q;
endmodule

// File: tb/tb_tess_topo_tri.sv
// Directed bench for tess_topo_tri with a queue scoreboard fed from an
// index model of the triangular point walk.
`timescale 1ns/1ps
module tb_tess_topo_tri;
  import tess_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_last, tri_ready;
  logic [7:0]  tess_level, in_i, in_j;
  logic        in_ready, tri_valid, tri_last, busy, seq_err;
  logic [15:0] tri_v0, tri_v1, tri_v2;

  tess_topo_tri dut (
    .clk(clk), .rst(rst), .start(start), .tess_level(tess_level),
    .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_j(in_j),
    .in_last(in_last), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2), .tri_last(tri_last),
    .busy(busy), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int        n_cmp = 0, n_err = 0;
  tess_tri_t exp_q[$];
  tess_tri_t saved, last_pop;
  int        occ = 0, n_pop = 0, m_L = 1, m_i = 0, m_j = 0;
  int        rdy_mode = 0, cyc = 0;
  bit        chk_rdy = 0, stalled = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Linear index of point (i,j) in a level-L patch.
  function automatic int idx(input int L, input int i, input int j);
    return i * (L + 1) - (i * (i - 1)) / 2 + j;
  endfunction

  initial begin
    tri_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      cyc++;
      tri_ready = (rdy_mode == 0) || (cyc % 3 == 0);
    end
  end

  // Observe handshakes mid-cycle; they take effect at the next rising edge.
  initial begin
    tess_tri_t e, cur;
    forever begin
      @(negedge clk);
      cur = '{v0: tri_v0, v1: tri_v1, v2: tri_v2, last: tri_last};
      if (chk_rdy && in_valid) check("in_ready_vs_free", 32'(in_ready), 32'(occ <= 2));
      if (tri_valid) begin
        if (stalled) begin
          check("stall_v0", 32'(cur.v0), 32'(saved.v0));
          check("stall_v1", 32'(cur.v1), 32'(saved.v1));
          check("stall_v2", 32'(cur.v2), 32'(saved.v2));
          check("stall_last", 32'(cur.last), 32'(saved.last));
        end
        if (tri_ready) begin
          if (exp_q.size() == 0) begin
            check("tri_unexpected", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("tri_v0", 32'(cur.v0), 32'(e.v0));
            check("tri_v1", 32'(cur.v1), 32'(e.v1));
            check("tri_v2", 32'(cur.v2), 32'(e.v2));
            check("tri_last", 32'(cur.last), 32'(e.last));
          end
          last_pop = cur;
          n_pop++;
          occ--;
        end
      end
      stalled = tri_valid && !tri_ready;
      saved   = cur;
      if (in_valid && in_ready) begin
        if (m_i > 0 && m_j > 0) begin
          exp_q.push_back('{v0: 16'(idx(m_L, m_i, m_j - 1)), v1: 16'(idx(m_L, m_i - 1, m_j)),
                            v2: 16'(idx(m_L, m_i, m_j)), last: 1'b0});
          occ++;
        end
        if (m_i > 0) begin
          exp_q.push_back('{v0: 16'(idx(m_L, m_i - 1, m_j)), v1: 16'(idx(m_L, m_i - 1, m_j + 1)),
                            v2: 16'(idx(m_L, m_i, m_j)), last: in_last});
          occ++;
        end
        if (m_j == m_L - m_i) begin m_i++; m_j = 0; end
        else m_j++;
      end
      if (start) begin
        m_L = (tess_level == 8'd0) ? 1 : int'(tess_level);
        m_i = 0; m_j = 0; occ = 0; n_pop = 0;
        exp_q.delete();
      end
      if (rst) begin
        exp_q.delete();
        occ = 0; stalled = 0;
      end
    end
  end

  task automatic do_start(input int L);
    start = 1'b1; tess_level = 8'(L);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_point(input int i, input int j, input bit last);
    bit acc = 0;
    in_i = 8'(i); in_j = 8'(j); in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 500 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
    check("point_accepted", 32'(acc), 32'd1);
  endtask

  task automatic send_patch(input int L, input bit bad);
    int lc = (L == 0) ? 1 : L;
    for (int i = 0; i <= lc; i++)
      for (int j = 0; j <= lc - i; j++) begin
        if (bad && i == 1 && j == 0) begin
          send_point(1, 1, 1'b0);
          check("seq_err_set", 32'(seq_err), 32'd1);
        end else begin
          send_point(i, j, (i == lc) && (j == 0));
        end
      end
  endtask

  task automatic wait_idle(input int limit);
    bit idle = 0;
    for (int k = 0; k < limit && !idle; k++) begin
      @(negedge clk);
      idle = !busy;
    end
    check("drain_idle", 32'(idle), 32'd1);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_tri_valid"}, 32'(tri_valid), 32'd0);
    check({tag, "_tri_v"}, 32'({tri_v0, tri_v1} | 32'(tri_v2)), 32'd0);
    check({tag, "_tri_last"}, 32'(tri_last), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_seq_err"}, 32'(seq_err), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; tess_level = 8'd0;
    in_valid = 1'b0; in_i = 8'd0; in_j = 8'd0; in_last = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // L=1 single triangle; first triangle visible the cycle after acceptance.
    do_start(1);
    send_point(0, 0, 1'b0);
    send_point(0, 1, 1'b0);
    send_point(1, 0, 1'b1);
    @(negedge clk);
    check("latency_tri_valid", 32'(tri_valid), 32'd1);
    wait_idle(100);
    check("l1_count", 32'(n_pop), 32'd1);
    check("l1_last_v2", 32'(last_pop.v2), 32'd2);

    // L=2 full stream.
    do_start(2);
    send_patch(2, 1'b0);
    wait_idle(100);
    check("l2_count", 32'(n_pop), 32'd4);
    check("l2_seq_err", 32'(seq_err), 32'd0);

    // Level 0 behaves as level 1.
    do_start(0);
    send_patch(0, 1'b0);
    wait_idle(100);
    check("l0_count", 32'(n_pop), 32'd1);

    // L=4 with output stalls: in_ready tracks FIFO space, outputs hold.
    rdy_mode = 1; chk_rdy = 1;
    do_start(4);
    send_patch(4, 1'b0);
    chk_rdy = 0;
    wait_idle(500);
    rdy_mode = 0;
    check("l4_count", 32'(n_pop), 32'd16);

    // Out-of-order point sets a sticky error; start clears it.
    do_start(2);
    send_patch(2, 1'b1);
    wait_idle(100);
    check("seq_err_sticky", 32'(seq_err), 32'd1);
    check("seq_err_count", 32'(n_pop), 32'd4);
    do_start(1);
    check("seq_err_cleared", 32'(seq_err), 32'd0);
    send_patch(1, 1'b0);
    wait_idle(100);

    // Reset mid-patch discards everything.
    do_start(3);
    send_point(0, 0, 1'b0);
    send_point(0, 1, 1'b0);
    send_point(0, 2, 1'b0);
    send_point(0, 3, 1'b0);
    send_point(1, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("midreset");
    do_start(1);
    send_patch(1, 1'b0);
    wait_idle(100);
    check("post_reset_count", 32'(n_pop), 32'd1);
    check("post_reset_v2", 32'(last_pop.v2), 32'd2);

    // Maximum level.
    do_start(255);
    send_patch(255, 1'b0);
    wait_idle(1000);
    check("l255_count", 32'(n_pop), 32'd65025);
    check("l255_last_v2", 32'(last_pop.v2), 32'd32895);
    check("l255_last_flag", 32'(last_pop.last), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
